// File: rtl/qsys_system_pio_pulse_out.sv
// rtl/qsys_system_pio_pulse_out.sv - Avalon-MM output PIO with atomic set/clear and retriggerable timed pulses
// out_port is the OR of a software data register and a hardware pulse mask timed by one shared down-counter.

module qsys_system_pio_pulse_out #(
    parameter int              WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int              LEN_W       = 16,
    parameter int              LEN_DEFAULT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLEAR  = 3'd2;
    localparam logic [2:0] ADDR_PULSE  = 3'd3;
    localparam logic [2:0] ADDR_LEN    = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic             wr;
    logic [WIDTH-1:0] wr_bits;
    logic             pulse_wr;
    logic             unused_wdata;

    assign wr       = chipselect && !write_n;
    assign wr_bits  = writedata[WIDTH-1:0];
    assign pulse_wr = wr && (address == ADDR_PULSE) && (wr_bits != '0);

    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= RESET_VALUE;
            mask_q  <= '0;
            cnt_q   <= '0;
            len_q   <= LEN_W'(LEN_DEFAULT);
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        if (wr) begin
            case (address)
                ADDR_DATA:  data_d = wr_bits;
                ADDR_SET:   data_d = data_q | wr_bits;
                ADDR_CLEAR: data_d = data_q & ~wr_bits;
                ADDR_LEN:   len_d  = writedata[LEN_W-1:0];
                default:    ;
            endcase
        end
    end

    // A trigger in the expiry cycle takes priority, so the bits it names never see a gap.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        if (pulse_wr) begin
            mask_d  = mask_q | wr_bits;
            cnt_d   = (len_q == '0) ? '0 : len_q - LEN_W'(1);
            state_d = ST_ACTIVE;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end else begin
                        mask_d  = '0;
                        state_d = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata[WIDTH-1:0] = data_q;
            ADDR_PULSE:  readdata[WIDTH-1:0] = mask_q;
            ADDR_LEN:    readdata[LEN_W-1:0] = len_q;
            ADDR_STATUS: readdata[0]         = (mask_q != '0);
            default:     ;
        endcase
    end

    assign out_port = data_q | mask_q;

endmodule

// File: tb/tb_qsys_system_pio_pulse_out.sv
// tb/tb_qsys_system_pio_pulse_out.sv - directed self-checking bench for qsys_system_pio_pulse_out

module tb_qsys_system_pio_pulse_out;

    localparam int          WIDTH = 4;
    localparam logic [3:0]  RV    = 4'h6;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [3:0]  out_port;

    int n_cmp;
    int n_fail;

    qsys_system_pio_pulse_out #(
        .WIDTH(WIDTH),
        .RESET_VALUE(RV),
        .LEN_W(16),
        .LEN_DEFAULT(1000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .readdata(readdata),
        .out_port(out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the write is sampled by the following posedge.
    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic check_read(input string tag, input logic [2:0] a, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(tag, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] exp);
        check(tag, {28'd0, out_port}, {28'd0, exp});
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        check_out("reset_out", RV);
        check_read("reset_len", 3'd4, 32'd1000);
        check_read("reset_status", 3'd5, 32'd0);

        bus_write(3'd0, 32'h0000_000A);
        check_out("data_out", 4'hA);
        check_read("data_read", 3'd0, 32'h0000_000A);

        // Asynchronous reset well away from any edge.
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_out("async_reset_out", RV);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        bus_write(3'd0, 32'h5);
        check_out("dat5", 4'h5);
        bus_write(3'd1, 32'h2);
        check_out("set2", 4'h7);
        bus_write(3'd2, 32'h4);
        check_out("clr4", 4'h3);
        check_read("set_addr_read", 3'd1, 32'h3);
        bus_write(3'd0, 32'hFFFF_FFFA);
        check_read("upper_zero", 3'd0, 32'h0000_000A);
        bus_write(3'd7, 32'hFFFF_FFFF);
        check_read("unused_read", 3'd6, 32'h0);
        check_out("unused_write_ignored", 4'hA);

        bus_write(3'd4, 32'd3);
        check_read("len3_read", 3'd4, 32'd3);
        bus_write(3'd0, 32'h0);
        bus_write(3'd3, 32'h1);
        check_out("p3_c1", 4'h1);
        check_read("p3_status_busy", 3'd5, 32'd1);
        check_read("p3_mask", 3'd3, 32'h1);
        @(negedge clk);
        check_out("p3_c2", 4'h1);
        @(negedge clk);
        check_out("p3_c3", 4'h1);
        @(negedge clk);
        check_out("p3_end", 4'h0);
        check_read("p3_status_idle", 3'd5, 32'd0);

        bus_write(3'd4, 32'd0);
        bus_write(3'd3, 32'h2);
        check_out("p0_c1", 4'h2);
        @(negedge clk);
        check_out("p0_end", 4'h0);

        bus_write(3'd4, 32'd4);
        bus_write(3'd3, 32'h1);
        check_out("rt_c1", 4'h1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_out("rt_c4", 4'h1);
        bus_write(3'd3, 32'h2);
        check_out("rt_n1", 4'h3);
        check_read("rt_mask", 3'd3, 32'h3);
        @(negedge clk);
        check_out("rt_n2", 4'h3);
        @(negedge clk);
        check_out("rt_n3", 4'h3);
        @(negedge clk);
        check_out("rt_n4", 4'h3);
        @(negedge clk);
        check_out("rt_end", 4'h0);
        bus_write(3'd3, 32'h0);
        check_out("zero_pulse_out", 4'h0);
        check_read("zero_pulse_status", 3'd5, 32'd0);

        bus_write(3'd0, 32'h1);
        bus_write(3'd4, 32'd5);
        bus_write(3'd3, 32'h1);
        bus_write(3'd2, 32'h1);
        check_read("ov_data_cleared", 3'd0, 32'h0);
        check_out("ov_c2", 4'h1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check_out("ov_c5", 4'h1);
        @(negedge clk);
        check_out("ov_end", 4'h0);

        bus_write(3'd4, 32'd100);
        bus_write(3'd3, 32'hF);
        repeat (9) @(negedge clk);
        check_out("mid_pulse_out", 4'hF);
        #2 reset = 1'b1;
        #1 check_out("mid_reset_out", RV);
        check_read("mid_reset_status", 3'd5, 32'd0);
        check_read("mid_reset_len", 3'd4, 32'd1000);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_out("post_reset_out", RV);
        check_read("post_reset_status", 3'd5, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
